pc_gen: RTL and testbench

- Parametrised program-counter generator for the fetch stage; next generation of the single-width free-running PC.
- Produces the fetch address `pc` and instruction-memory enable `ce`.
- Supports pipeline stall, branch/jump redirect, and exception/flush redirect.
- Holds a branch that arrives during a stall and applies it when the stall releases.

---
 rtl/pc_gen.sv | 123 ++++++++++++
 tb/tb_pc_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Handles warm-up, stall, branch redirect, flush redirect, and a branch captured during a stall.
// Optional feature macro: PC_ALIGN_CHECK_EN (redirect-target alignment check and misalign pulse).
module pc_gen #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0,
    parameter int unsigned INC       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              redirect_pending,
    output logic              misalign
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INC);
`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              ce_nxt;
    logic              pend_nxt;
    logic [ADDR_W-1:0] ptgt_nxt;
    logic              mis_nxt;
    logic              redir;
    logic [ADDR_W-1:0] redir_tgt;
    logic [ADDR_W-1:0] pending_target;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: IDLE lasts exactly one edge after reset release
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Next pc / pending / misalign, redirect priority flush > stall > live branch > pending > increment
    always_comb begin
        pc_nxt    = pc;
        pend_nxt  = redirect_pending;
        ptgt_nxt  = pending_target;
        mis_nxt   = 1'b0;
        redir     = 1'b0;
        redir_tgt = '0;
        ce_nxt    = (state_nxt == RUN);

        if (state == RUN) begin
            if (flush) begin
                redir     = 1'b1;
                redir_tgt = new_pc;
                pend_nxt  = 1'b0;
            end else if (stall) begin
                if (branch_flag) begin
                    ptgt_nxt = branch_target;
                    pend_nxt = 1'b1;
                end
            end else if (branch_flag) begin
                redir     = 1'b1;
                redir_tgt = branch_target;
                pend_nxt  = 1'b0;
            end else if (redirect_pending) begin
                redir     = 1'b1;
                redir_tgt = pending_target;
                pend_nxt  = 1'b0;
            end else begin
                pc_nxt = pc + STEP;
            end
        end

        if (redir) begin
`ifdef PC_ALIGN_CHECK_EN
            pc_nxt  = redir_tgt & ~ALIGN_MASK;
            mis_nxt = |(redir_tgt & ALIGN_MASK);
`else
            pc_nxt  = redir_tgt;
`endif
        end
    end

    // Output and storage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc               <= RST_PC;
            ce               <= 1'b0;
            redirect_pending <= 1'b0;
            pending_target   <= '0;
            misalign         <= 1'b0;
        end else begin
            pc               <= pc_nxt;
            ce               <= ce_nxt;
            redirect_pending <= pend_nxt;
            pending_target   <= ptgt_nxt;
            misalign         <= mis_nxt;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen, a 32-bit and an 8-bit instance share control inputs.
module tb_pc_gen;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam int unsigned INC = 4;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;

    logic [31:0] pc;
    logic        ce;
    logic        rp;
    logic        mis;
    logic [7:0]  pc8;
    logic        ce8;
    logic        rp8;
    logic        mis8;

    int total = 0;
    int bad   = 0;

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .INC(INC)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .pc(pc), .ce(ce), .redirect_pending(rp), .misalign(mis)
    );

    pc_gen #(.ADDR_W(8), .RESET_VEC(32'h0), .INC(INC)) u_dut8 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc[7:0]),
        .branch_flag(branch_flag), .branch_target(branch_target[7:0]),
        .pc(pc8), .ce(ce8), .redirect_pending(rp8), .misalign(mis8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: spec rules in plain arithmetic, width given by mask
    typedef struct {
        bit          run;
        bit          pend;
        bit          mis;
        logic [31:0] pc;
        logic [31:0] ptgt;
    } model_t;

    function automatic model_t m_reset();
        model_t m;
        m.run = 1'b0; m.pend = 1'b0; m.mis = 1'b0; m.pc = 32'h0; m.ptgt = 32'h0;
        return m;
    endfunction

    function automatic model_t m_jump(input model_t mi, input logic [31:0] t, input logic [31:0] msk);
        model_t m;
        logic [31:0] tt;
        m  = mi;
        tt = t & msk;
        if (ALIGN && (tt % INC) != 0) begin
            m.mis = 1'b1;
            m.pc  = tt - (tt % INC);
        end else begin
            m.pc = tt;
        end
        return m;
    endfunction

    function automatic model_t m_step(input model_t mi, input logic [31:0] msk);
        model_t m;
        m     = mi;
        m.mis = 1'b0;
        if (!m.run) begin
            m.run = 1'b1;
        end else if (flush) begin
            m      = m_jump(m, new_pc, msk);
            m.pend = 1'b0;
        end else if (stall) begin
            if (branch_flag) begin
                m.ptgt = branch_target & msk;
                m.pend = 1'b1;
            end
        end else if (branch_flag) begin
            m      = m_jump(m, branch_target, msk);
            m.pend = 1'b0;
        end else if (m.pend) begin
            m      = m_jump(m, m.ptgt, msk);
            m.pend = 1'b0;
        end else begin
            m.pc = (m.pc + INC) & msk;
        end
        return m;
    endfunction

    model_t m32;
    model_t m8;

    // Model state advances with the same edges as the DUTs
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m32 <= m_reset();
            m8  <= m_reset();
        end else begin
            m32 <= m_step(m32, 32'hFFFF_FFFF);
            m8  <= m_step(m8, 32'h0000_00FF);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_pc",   pc,           m32.pc);
        chk("m_ce",   32'(ce),      32'(m32.run));
        chk("m_rp",   32'(rp),      32'(m32.pend));
        chk("m_mis",  32'(mis),     32'(m32.mis));
        chk("m_pc8",  32'(pc8),     m8.pc);
        chk("m_ce8",  32'(ce8),     32'(m8.run));
        chk("m_rp8",  32'(rp8),     32'(m8.pend));
        chk("m_mis8", 32'(mis8),    32'(m8.mis));
    end

    logic [31:0] seq [4];

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; new_pc = '0;
        branch_flag = 1'b0; branch_target = '0;
        seq[0] = 32'h4; seq[1] = 32'h8; seq[2] = 32'hC; seq[3] = 32'h10;

        // Reset and warm-up
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ce", 32'(ce), 32'h0);
        chk("rst_rp", 32'(rp), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("warm_ce", 32'(ce), 32'h1);
        chk("warm_pc", pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("seq_pc", pc, seq[i]);
        end

        // Branch from 0x10
        branch_flag = 1'b1; branch_target = 32'h100;
        @(negedge clk);
        branch_flag = 1'b0;
        chk("br_pc", pc, 32'h100);
        chk("br_rp", 32'(rp), 32'h0);
        @(negedge clk);
        chk("br_pc2", pc, 32'h104);

        // Stall capture at 0x20, latest branch wins
        branch_flag = 1'b1; branch_target = 32'h20;
        @(negedge clk);
        branch_flag = 1'b0; stall = 1'b1;
        @(negedge clk);
        branch_flag = 1'b1; branch_target = 32'h200;
        @(negedge clk);
        chk("st_rp", 32'(rp), 32'h1);
        branch_target = 32'h300;
        @(negedge clk);
        branch_flag = 1'b0;
        @(negedge clk);
        chk("st_pc", pc, 32'h20);
        chk("st_rp2", 32'(rp), 32'h1);
        stall = 1'b0;
        @(negedge clk);
        chk("st_rel_pc", pc, 32'h300);
        chk("st_rel_rp", 32'(rp), 32'h0);
        @(negedge clk);
        chk("st_rel_pc2", pc, 32'h304);

        // Flush beats stall, branch and pending
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h400;
        @(negedge clk);
        flush = 1'b1; new_pc = 32'h80;
        @(negedge clk);
        flush = 1'b0; stall = 1'b0; branch_flag = 1'b0;
        chk("fl_pc", pc, 32'h80);
        chk("fl_rp", 32'(rp), 32'h0);
        @(negedge clk);
        chk("fl_pc2", pc, 32'h84);

        // Live branch beats stored pending
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h500;
        @(negedge clk);
        stall = 1'b0; branch_target = 32'h600;
        @(negedge clk);
        branch_flag = 1'b0;
        chk("live_pc", pc, 32'h600);
        chk("live_rp", 32'(rp), 32'h0);

        // Misaligned live branch
        branch_flag = 1'b1; branch_target = 32'h102;
        @(negedge clk);
        branch_flag = 1'b0;
        chk("mal_pc", pc, ALIGN ? 32'h100 : 32'h102);
        chk("mal_mis", 32'(mis), ALIGN ? 32'h1 : 32'h0);
        @(negedge clk);
        chk("mal_mis_end", 32'(mis), 32'h0);

        // Misaligned stall-captured branch
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h203;
        @(negedge clk);
        chk("malp_mis_hold", 32'(mis), 32'h0);
        stall = 1'b0; branch_flag = 1'b0;
        @(negedge clk);
        chk("malp_pc", pc, ALIGN ? 32'h200 : 32'h203);
        chk("malp_mis", 32'(mis), ALIGN ? 32'h1 : 32'h0);

        // 8-bit wrap
        branch_flag = 1'b1; branch_target = 32'hFC;
        @(negedge clk);
        branch_flag = 1'b0;
        chk("wrap_pc8_a", 32'(pc8), 32'hFC);
        @(negedge clk);
        chk("wrap_pc8_b", 32'(pc8), 32'h00);
        chk("wrap_pc32", pc, 32'h100);

        // Asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_ce", 32'(ce), 32'h0);
        chk("arst_pc8", 32'(pc8), 32'h0);
        chk("arst_rp", 32'(rp), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        // IDLE edge ignores the flush; the next edge applies it
        flush = 1'b1; new_pc = 32'h31; stall = 1'b1;
        @(negedge clk);
        chk("idle_pc", pc, 32'h0);
        chk("idle_ce", 32'(ce), 32'h1);
        @(negedge clk);
        flush = 1'b0; stall = 1'b0;
        chk("rs_fl_pc", pc, ALIGN ? 32'h30 : 32'h31);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
